line_mem_responder: RTL and testbench

Synthesizable memory-side responder for the cache's line-granular memory port. It answers `mem_read`/`mem_write` requests with a single-cycle `mem_resp` after a fixed, parameterized latency, and backs the requests with a small internal line array. It sits below the cache controller in place of physical memory, for block-level and integration benches and for FPGA bring-up.

---
 rtl/line_mem_responder.sv | 157 +++++++++++++++
 tb/tb_line_mem_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// line_mem_responder
//   Memory-side responder for a cache's line-granular memory port. Each
//   mem_read/mem_write request is answered with a one-cycle mem_resp exactly
//   LATENCY cycles after it is first sampled in IDLE. A small internal line
//   array backs the requests.
//
// Parameters
//   LINE_BITS  : cacheline width in bits
//   DEPTH_LOG2 : log2 of the number of stored lines
//   LATENCY    : request-sample to mem_resp distance in cycles (1..15)
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous, active-low reset
//   mem_read    : line read request, held until mem_resp
//   mem_write   : line write request, held until mem_resp (wins over read)
//   mem_address : byte address; line index = mem_address[5 +: DEPTH_LOG2]
//   mem_wdata   : write line
//   mem_rdata   : registered read line, holds until the next read response
//   mem_resp    : registered one-cycle completion pulse
//   proto_err   : sticky protocol-error flag
//
// Build option
//   LINE_MEM_PROTO_CHECK_EN : when defined, proto_err flags simultaneous
//   read/write, a request dropped while BUSY, or address/op changing while
//   BUSY. When undefined the checker is absent and proto_err is 0.

module line_mem_responder #(
  parameter int unsigned LINE_BITS  = 256,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          mem_address,
  input  logic [LINE_BITS-1:0] mem_wdata,
  output logic [LINE_BITS-1:0] mem_rdata,
  output logic                 mem_resp,
  output logic                 proto_err
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  op_wr_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [LINE_BITS-1:0]  wdata_q;
  logic                  resp_q;
  logic [LINE_BITS-1:0]  rdata_q;
  logic [LINE_BITS-1:0]  array_q [DEPTH];

  logic                  req;
  logic [DEPTH_LOG2-1:0] addr_idx;
  logic                  unused_addr;

  assign req         = mem_read | mem_write;
  assign addr_idx    = mem_address[5 +: DEPTH_LOG2];
  // Offset and alias bits do not select a line.
  assign unused_addr = ^{mem_address[31:5+DEPTH_LOG2], mem_address[4:0]};

  // Control FSM with registered response and read data. mem_resp and the read
  // line are both loaded on the edge entering RESP, so they line up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      resp_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            op_wr_q <= mem_write;
            idx_q   <= addr_idx;
            wdata_q <= mem_wdata;
            cnt_q   <= LAT_M1;
            if (LATENCY == 1) begin
              state_q <= RESP;
              resp_q  <= 1'b1;
              if (!mem_write) rdata_q <= array_q[addr_idx];
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            resp_q  <= 1'b1;
            if (!op_wr_q) rdata_q <= array_q[idx_q];
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Writes commit on the edge leaving RESP so a read sampled in the following
  // IDLE cycle already sees the new line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        array_q[i] <= '0;
      end
    end else if (state_q == RESP && op_wr_q) begin
      array_q[idx_q] <= wdata_q;
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;

`ifdef LINE_MEM_PROTO_CHECK_EN
  logic [31:0] chk_addr_q;
  logic        err_q;
  logic        busy_viol;

  // While BUSY the initiator must hold the same op and full address.
  assign busy_viol = (state_q == BUSY) &&
                     (!req || (mem_address != chk_addr_q) || (mem_write != op_wr_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && req) chk_addr_q <= mem_address;
      if ((mem_read && mem_write) || busy_viol) err_q <= 1'b1;
    end
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: instance A uses LATENCY=4, instance B
// uses LATENCY=1. Both share clock and reset.

module tb_line_mem_responder;

  localparam int unsigned LB = 256;

  localparam logic [LB-1:0] PA5 = {32{8'hA5}};
  localparam logic [LB-1:0] P3C = {32{8'h3C}};
  localparam logic [LB-1:0] PF0 = {16{16'hF00D}};
  localparam logic [LB-1:0] P77 = {32{8'h77}};
  localparam logic [LB-1:0] PFF = {32{8'hFF}};
  localparam logic [LB-1:0] P5A = {32{8'h5A}};
  localparam logic [LB-1:0] PC3 = {8{32'hC0FFEE11}};

`ifdef LINE_MEM_PROTO_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk;
  logic          rst;

  logic          a_read, a_write;
  logic [31:0]   a_addr;
  logic [LB-1:0] a_wdata, a_rdata;
  logic          a_resp, a_err;

  logic          b_read, b_write;
  logic [31:0]   b_addr;
  logic [LB-1:0] b_wdata, b_rdata;
  logic          b_resp, b_err;

  int pass_cnt;
  int total_cnt;

  line_mem_responder #(.LINE_BITS(LB), .DEPTH_LOG2(4), .LATENCY(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .mem_read(a_read), .mem_write(a_write), .mem_address(a_addr),
    .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_resp(a_resp),
    .proto_err(a_err)
  );

  line_mem_responder #(.LINE_BITS(LB), .DEPTH_LOG2(4), .LATENCY(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .mem_read(b_read), .mem_write(b_write), .mem_address(b_addr),
    .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_resp(b_resp),
    .proto_err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to 1 time unit after the next rising edge: inputs are driven and
  // outputs sampled there, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request on instance A starting in the current cycle (cycle 0),
  // waits up to 20 cycles for mem_resp, drops the request and steps one more
  // cycle. lat = cycle of the first mem_resp (-1 on timeout), extra = mem_resp
  // in the cycle after it.
  task automatic run_txn_a(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [LB-1:0] wd, output int lat,
                           output logic [LB-1:0] rdat, output logic extra);
    a_write = wr;
    a_read  = rd;
    a_addr  = addr;
    a_wdata = wd;
    lat     = -1;
    rdat    = '0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      if (a_resp) begin
        lat  = c;
        rdat = a_rdata;
      end
    end
    a_write = 1'b0;
    a_read  = 1'b0;
    tick();
    extra = a_resp;
  endtask

  task automatic test_reset();
    total_cnt++;
    if (a_resp !== 1'b0) $display("FAIL reset_resp: got %b expected 0", a_resp);
    else pass_cnt++;
    total_cnt++;
    if (a_rdata !== '0) $display("FAIL reset_rdata: got %h expected 0", a_rdata);
    else pass_cnt++;
    total_cnt++;
    if (a_err !== 1'b0) $display("FAIL reset_proto_err: got %b expected 0", a_err);
    else pass_cnt++;
    total_cnt++;
    if (b_resp !== 1'b0) $display("FAIL reset_resp_b: got %b expected 0", b_resp);
    else pass_cnt++;
  endtask

  task automatic test_first_read();
    int lat;
    logic [LB-1:0] rd;
    logic extra;
    run_txn_a(1'b0, 1'b1, 32'h0000_0060, '0, lat, rd, extra);
    total_cnt++;
    if (lat !== 4) $display("FAIL read0_latency: got %0d expected 4", lat);
    else pass_cnt++;
    total_cnt++;
    if (rd !== '0) $display("FAIL read0_data: got %h expected 0", rd);
    else pass_cnt++;
    total_cnt++;
    if (extra !== 1'b0) $display("FAIL read0_pulse_width: got %b expected 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    int lat;
    logic [LB-1:0] rd;
    logic extra;
    // Write issued at cycle 0 responds at 4; read issued at cycle 6 responds at 10.
    run_txn_a(1'b1, 1'b0, 32'h0000_0040, PA5, lat, rd, extra);
    total_cnt++;
    if (lat !== 4) $display("FAIL write_latency: got %0d expected 4", lat);
    else pass_cnt++;
    tick();
    run_txn_a(1'b0, 1'b1, 32'h0000_0040, '0, lat, rd, extra);
    total_cnt++;
    if (6 + lat !== 10) $display("FAIL read_resp_cycle: got %0d expected 10", 6 + lat);
    else pass_cnt++;
    total_cnt++;
    if (rd !== PA5) $display("FAIL read_written: got %h expected %h", rd, PA5);
    else pass_cnt++;
    run_txn_a(1'b0, 1'b1, 32'h0000_0080, '0, lat, rd, extra);
    total_cnt++;
    if (rd !== '0) $display("FAIL read_other_idx: got %h expected 0", rd);
    else pass_cnt++;
    // Reload rdata with A5, then a write must leave it untouched.
    run_txn_a(1'b0, 1'b1, 32'h0000_0040, '0, lat, rd, extra);
    run_txn_a(1'b1, 1'b0, 32'h0000_00A0, P3C, lat, rd, extra);
    total_cnt++;
    if (a_rdata !== PA5) $display("FAIL rdata_hold_on_write: got %h expected %h", a_rdata, PA5);
    else pass_cnt++;
    total_cnt++;
    if (a_err !== 1'b0) $display("FAIL proto_err_clean: got %b expected 0", a_err);
    else pass_cnt++;
  endtask

  task automatic test_alias();
    int lat;
    logic [LB-1:0] rd;
    logic extra;
    run_txn_a(1'b1, 1'b0, 32'h0000_0020, PF0, lat, rd, extra);
    run_txn_a(1'b0, 1'b1, 32'h0000_0220, '0, lat, rd, extra);
    total_cnt++;
    if (rd !== PF0) $display("FAIL alias_idx1: got %h expected %h", rd, PF0);
    else pass_cnt++;
    // Top index with nonzero offset bits and high alias bits.
    run_txn_a(1'b1, 1'b0, 32'h0000_01E0, P77, lat, rd, extra);
    run_txn_a(1'b0, 1'b1, 32'hFFFF_FFFF, '0, lat, rd, extra);
    total_cnt++;
    if (rd !== P77) $display("FAIL alias_idx15: got %h expected %h", rd, P77);
    else pass_cnt++;
    run_txn_a(1'b0, 1'b1, 32'h0000_0000, '0, lat, rd, extra);
    total_cnt++;
    if (rd !== '0) $display("FAIL alias_idx0_untouched: got %h expected 0", rd);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [LB-1:0] rd;
    logic extra;
    // Read sampled in the very cycle after the write's RESP.
    run_txn_a(1'b1, 1'b0, 32'h0000_00A0, P5A, lat, rd, extra);
    run_txn_a(1'b0, 1'b1, 32'h0000_00A0, '0, lat, rd, extra);
    total_cnt++;
    if (lat !== 4) $display("FAIL b2b_latency: got %0d expected 4", lat);
    else pass_cnt++;
    total_cnt++;
    if (rd !== P5A) $display("FAIL b2b_data: got %h expected %h", rd, P5A);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int lat;
    logic [LB-1:0] rd;
    logic extra;
    int seen;
    a_write = 1'b1;
    a_addr  = 32'h0000_00E0;
    a_wdata = PFF;
    tick();
    tick();
    rst     = 1'b0;
    a_write = 1'b0;
    #1;
    total_cnt++;
    if (a_resp !== 1'b0) $display("FAIL abort_resp_in_reset: got %b expected 0", a_resp);
    else pass_cnt++;
    tick();
    tick();
    rst  = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (a_resp) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL abort_no_resp: got %0d pulses expected 0", seen);
    else pass_cnt++;
    run_txn_a(1'b0, 1'b1, 32'h0000_00E0, '0, lat, rd, extra);
    total_cnt++;
    if (lat !== 4) $display("FAIL abort_idle_latency: got %0d expected 4", lat);
    else pass_cnt++;
    total_cnt++;
    if (rd !== '0) $display("FAIL abort_no_write: got %h expected 0", rd);
    else pass_cnt++;
    // Reset also cleared the line written earlier.
    run_txn_a(1'b0, 1'b1, 32'h0000_0040, '0, lat, rd, extra);
    total_cnt++;
    if (rd !== '0) $display("FAIL reset_clears_array: got %h expected 0", rd);
    else pass_cnt++;
  endtask

  task automatic test_latency1();
    logic [4:0] pat;
    b_read = 1'b1;
    b_addr = 32'h0000_0020;
    for (int c = 1; c <= 5; c++) begin
      tick();
      pat[c-1] = b_resp;
      if (c == 3) b_read = 1'b0;
    end
    total_cnt++;
    if (pat !== 5'b00101) $display("FAIL lat1_resp_pattern: got %b expected 00101", pat);
    else pass_cnt++;
    b_write = 1'b1;
    b_wdata = PC3;
    tick();
    total_cnt++;
    if (b_resp !== 1'b1) $display("FAIL lat1_write_resp: got %b expected 1", b_resp);
    else pass_cnt++;
    b_write = 1'b0;
    tick();
    b_read = 1'b1;
    tick();
    b_read = 1'b0;
    total_cnt++;
    if (b_resp !== 1'b1 || b_rdata !== PC3)
      $display("FAIL lat1_readback: got resp=%b data=%h expected resp=1 data=%h", b_resp, b_rdata, PC3);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (b_err !== 1'b0) $display("FAIL lat1_proto_err: got %b expected 0", b_err);
    else pass_cnt++;
  endtask

  task automatic test_proto();
    int lat;
    logic [LB-1:0] rd;
    logic extra;
    run_txn_a(1'b1, 1'b1, 32'h0000_0100, P3C, lat, rd, extra);
    total_cnt++;
    if (lat !== 4) $display("FAIL both_latency: got %0d expected 4", lat);
    else pass_cnt++;
    total_cnt++;
    if (a_err !== EXP_ERR) $display("FAIL both_proto_err: got %b expected %b", a_err, EXP_ERR);
    else pass_cnt++;
    run_txn_a(1'b0, 1'b1, 32'h0000_0100, '0, lat, rd, extra);
    total_cnt++;
    if (rd !== P3C) $display("FAIL both_write_wins: got %h expected %h", rd, P3C);
    else pass_cnt++;
    total_cnt++;
    if (a_err !== EXP_ERR) $display("FAIL proto_err_sticky: got %b expected %b", a_err, EXP_ERR);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    total_cnt++;
    if (a_err !== 1'b0) $display("FAIL proto_err_reset: got %b expected 0", a_err);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst     = 1'b0;
    a_read  = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
    b_read  = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();

    test_reset();
    test_first_read();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_reset_abort();
    test_latency1();
    test_proto();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
